// File: rtl/key_switch_input.sv
// Debounced DIP switches and push keys with sticky W1C key-press events; KEY_IRQ_EN adds CTRL and irq.
// Latency: rdata combinational, debounce worst case 2+3*SAMPLE_PERIOD+1 cycles; no backpressure, bus always accepted.
module key_switch_input #(
  parameter int SAMPLE_PERIOD = 25_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic        en,
  input  logic        Wen,
  input  logic [3:0]  ByteEn,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] switch_raw,
  input  logic [7:0]  key_raw_n,
  output logic        irq
);

  localparam int CW = $clog2(SAMPLE_PERIOD);

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [31:0]   sw_s1, sw_s2;
  logic [7:0]    key_s1, key_s2;
  logic [39:0]   in_sync, hist0, hist1, db;
  logic [39:0]   all_one, all_zero;
  logic [7:0]    key_prev, key_rise, evt, evt_clr;
  logic [31:0]   ctrl_rd;
  logic [1:0]    off;
  logic          wr;
  logic          unused_bits;

  assign tick = (tick_cnt == CW'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // Keys reset to the released level so reset release never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= 8'hFF;
      key_s2 <= 8'hFF;
    end else begin
      sw_s1  <= switch_raw;
      sw_s2  <= sw_s1;
      key_s1 <= key_raw_n;
      key_s2 <= key_s1;
    end
  end

  assign in_sync = {~key_s2, sw_s2};

  // The incoming sample is the newest history entry, so the decision uses it directly.
  assign all_one  = in_sync & hist0 & hist1;
  assign all_zero = ~(in_sync | hist0 | hist1);

  always_ff @(posedge clk) begin
    if (reset) begin
      hist0 <= '0;
      hist1 <= '0;
      db    <= '0;
    end else if (tick) begin
      hist0 <= in_sync;
      hist1 <= hist0;
      db    <= (db | all_one) & ~all_zero;
    end
  end

  assign wr       = en & Wen;
  assign off      = addr[3:2];
  assign key_rise = db[39:32] & ~key_prev;
  assign evt_clr  = (wr && off == 2'd2 && ByteEn[0]) ? wdata[7:0] : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_prev <= '0;
      evt      <= '0;
    end else begin
      key_prev <= db[39:32];
      evt      <= (evt & ~evt_clr) | key_rise;
    end
  end

`ifdef KEY_IRQ_EN
  logic [7:0] evt_mask;
  logic       irq_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_mask <= '0;
      irq_en   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr && off == 2'd3) begin
        if (ByteEn[0]) evt_mask <= wdata[7:0];
        if (ByteEn[1]) irq_en   <= wdata[8];
      end
      irq <= irq_en & |(evt & evt_mask);
    end
  end

  assign ctrl_rd = {23'h0, irq_en, evt_mask};
`else
  assign ctrl_rd = 32'h0;
  assign irq     = 1'b0;
`endif

  assign unused_bits = ^{addr[31:4], ByteEn[3:1], wdata[31:8]};

  always_comb begin
    rdata = 32'h0;
    if (en) begin
      case (off)
        2'd0: rdata = db[31:0];
        2'd1: rdata = {24'h0, db[39:32]};
        2'd2: rdata = {24'h0, evt};
        default: rdata = ctrl_rd;
      endcase
    end
  end

endmodule

// File: tb/tb_key_switch_input.sv
// Bench for key_switch_input: directed scenarios plus randomized traffic against a behavioural model.
module tb_key_switch_input;
  localparam int P = 4;
`ifdef KEY_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:2] addr = '0;
  logic        en = 1'b0;
  logic        Wen = 1'b0;
  logic [3:0]  ByteEn = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [31:0] switch_raw = 32'h0;
  logic [7:0]  key_raw_n = 8'hFF;
  logic        irq;

  int n_checks = 0;
  int n_fail = 0;

  key_switch_input #(.SAMPLE_PERIOD(P)) dut (
    .clk(clk), .reset(reset), .addr(addr), .en(en), .Wen(Wen), .ByteEn(ByteEn),
    .wdata(wdata), .rdata(rdata), .switch_raw(switch_raw), .key_raw_n(key_raw_n), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: delay line, sample queue, tick from cycle count since reset.
  logic [39:0] m_p0, m_p1, m_db;
  logic [39:0] m_hist[$];
  logic [7:0]  m_kprev, m_evt, m_mask;
  logic        m_ie, m_irq;
  int          m_cyc;

  always @(posedge clk) begin : model
    logic [39:0] insync;
    logic [7:0]  rise, clr;
    logic        irq_next;
    bit          tick;
    if (reset) begin
      m_p0 = '0; m_p1 = '0; m_db = '0;
      m_hist = {40'h0, 40'h0, 40'h0};
      m_kprev = '0; m_evt = '0; m_mask = '0; m_ie = 1'b0; m_irq = 1'b0;
      m_cyc = 0;
    end else begin
      insync = m_p1;
      tick = (m_cyc % P) == (P - 1);
      m_cyc++;
      rise = m_db[39:32] & ~m_kprev;
      m_kprev = m_db[39:32];
      irq_next = m_ie && ((m_evt & m_mask) != 8'h0);
      clr = (en && Wen && addr[3:2] == 2'd2 && ByteEn[0]) ? wdata[7:0] : 8'h0;
      m_evt = (m_evt & ~clr) | rise;
      if (IRQ_EN && en && Wen && addr[3:2] == 2'd3) begin
        if (ByteEn[0]) m_mask = wdata[7:0];
        if (ByteEn[1]) m_ie = wdata[8];
      end
      m_irq = IRQ_EN ? irq_next : 1'b0;
      if (tick) begin
        m_hist.push_front(insync);
        void'(m_hist.pop_back());
        for (int b = 0; b < 40; b++)
          if (m_hist[0][b] == m_hist[1][b] && m_hist[1][b] == m_hist[2][b]) m_db[b] = m_hist[0][b];
      end
      m_p1 = m_p0;
      m_p0 = {~key_raw_n, switch_raw};
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] off);
    case (off)
      2'd0: return m_db[31:0];
      2'd1: return {24'h0, m_db[39:32]};
      2'd2: return {24'h0, m_evt};
      default: return {23'h0, m_ie, m_mask};
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
    addr = 30'(off); en = 1'b1; Wen = 1'b0;
    #1 d = rdata;
    en = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    addr = 30'(off); en = 1'b1; Wen = 1'b1; wdata = data; ByteEn = be;
    @(negedge clk);
    en = 1'b0; Wen = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    for (int o = 0; o < 4; o++) begin
      bus_read(2'(o), d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_rd off=%0d got=%h exp=%h", o, d, 32'h0); end
    end
    addr = 30'd1; en = 1'b0;
    #1;
    n_checks++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL en_low got=%h exp=%h", rdata, 32'h0); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_switch;
    logic [31:0] d;
    int n = 0;
    bit found = 0;
    @(negedge clk);
    switch_raw = 32'hA5A5_0F0F;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      n++;
      bus_read(2'd0, d);
      n_checks++;
      if (d !== model_rd(2'd0)) begin n_fail++; $display("FAIL switch_model cyc=%0d got=%h exp=%h", n, d, model_rd(2'd0)); end
      if (d == 32'hA5A5_0F0F) found = 1;
    end
    n_checks++;
    if (!found || n < 11 || n > 15) begin n_fail++; $display("FAIL switch_latency found=%0d got=%0d exp=11..15", found, n); end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    @(negedge clk);
    key_raw_n = 8'hF7;
    step(3);
    key_raw_n = 8'hFF;
    step(20);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_key got=%h exp=%h", d, 32'h0); end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_event got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_key_irq;
    logic [31:0] d;
    bit found = 0;
    @(negedge clk);
    key_raw_n = 8'hF7;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      bus_read(2'd1, d);
      if (d == 32'h8) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL key_press got=%h exp=%h", d, 32'h8); end
    step(1);
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL event_set got=%h exp=%h", d, 32'h8); end
    bus_write(2'd3, 32'h108, 4'b0011);
    step(1);
    n_checks++;
    if (irq !== IRQ_EN) begin n_fail++; $display("FAIL irq_assert got=%b exp=%b", irq, IRQ_EN); end
    bus_read(2'd3, d);
    n_checks++;
    if (d !== (IRQ_EN ? 32'h108 : 32'h0)) begin n_fail++; $display("FAIL ctrl_rd got=%h exp=%h", d, IRQ_EN ? 32'h108 : 32'h0); end
    bus_write(2'd2, 32'h8, 4'b0001);
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL w1c got=%h exp=%h", d, 32'h0); end
    n_checks++;
    if (irq !== IRQ_EN) begin n_fail++; $display("FAIL irq_hold got=%b exp=%b", irq, IRQ_EN); end
    step(1);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall got=%b exp=0", irq); end
    key_raw_n = 8'hFF;
    step(20);
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL release_event got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_collision;
    logic [31:0] d;
    bit found = 0;
    @(negedge clk);
    key_raw_n = 8'hFE;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      bus_read(2'd1, d);
      if (d[0]) begin
        found = 1;
        addr = 30'd2; en = 1'b1; Wen = 1'b1; wdata = 32'h1; ByteEn = 4'b0001;
        @(negedge clk);
        en = 1'b0; Wen = 1'b0;
        bus_read(2'd2, d);
        n_checks++;
        if (d[0] !== 1'b1) begin n_fail++; $display("FAIL set_wins got=%h exp=%h", d, 32'h1); end
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL key0_press got=0 exp=1"); end
    bus_write(2'd2, 32'h1, 4'b0001);
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_key0 got=%h exp=%h", d, 32'h0); end
    key_raw_n = 8'hFF;
    step(20);
  endtask

  task automatic test_ctrl_bytes;
    logic [31:0] d;
    bus_write(2'd3, 32'h0, 4'b0011);
    bus_write(2'd3, 32'hFFFF_FFFF, 4'b0001);
    bus_read(2'd3, d);
    n_checks++;
    if (d !== (IRQ_EN ? 32'hFF : 32'h0)) begin n_fail++; $display("FAIL ctrl_be0 got=%h exp=%h", d, IRQ_EN ? 32'hFF : 32'h0); end
    step(2);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ctrl_irq got=%b exp=0", irq); end
    bus_write(2'd3, 32'hFFFF_FFFF, 4'b1110);
    bus_read(2'd3, d);
    n_checks++;
    if (d !== (IRQ_EN ? 32'h1FF : 32'h0)) begin n_fail++; $display("FAIL ctrl_be1 got=%h exp=%h", d, IRQ_EN ? 32'h1FF : 32'h0); end
  endtask

  task automatic test_random;
    logic [31:0] d;
    logic [1:0]  off;
    int hold = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      en = 1'b0; Wen = 1'b0;
      if (c == 700) reset = 1'b1;
      if (c == 703) reset = 1'b0;
      off = 2'($urandom_range(0, 3));
      bus_read(off, d);
      n_checks++;
      if (d !== model_rd(off)) begin n_fail++; $display("FAIL rand_rd c=%0d off=%0d got=%h exp=%h", c, off, d, model_rd(off)); end
      n_checks++;
      if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq c=%0d got=%b exp=%b", c, irq, m_irq); end
      if (hold == 0) begin
        hold = $urandom_range(1, 20);
        if ($urandom_range(0, 1) == 1) switch_raw = switch_raw ^ $urandom;
        else key_raw_n = 8'($urandom);
      end else hold--;
      if ($urandom_range(0, 5) == 0) begin
        addr = 30'($urandom); en = 1'b1; Wen = 1'b1; ByteEn = 4'($urandom); wdata = $urandom;
      end
    end
    @(negedge clk);
    en = 1'b0; Wen = 1'b0;
  endtask

  initial begin
    test_reset();
    test_switch();
    test_glitch();
    test_key_irq();
    test_collision();
    test_ctrl_bytes();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
